// File: rtl/dist_calc_control_if.sv
// Control/BRAM bundle between dist_calc_control (master) and the distance datapath (slave).
interface dist_calc_control_if #(
  parameter int ADDR_W = 8,
  parameter int ELEM_W = 4,
  parameter int VEC_W  = 4
);
  logic              STARTCALC;
  logic [VEC_W-1:0]  NUM_OF_VECTORS;
  logic [ELEM_W-1:0] VECTOR_WIDTH;
  logic              RDY_Pipe;
  logic              RDY_Acc;
  logic              RDY_Sqrt;
  logic              EN_Pipe;
  logic              EN_Acc;
  logic              EN_Sqrt;
  logic              RST_Acc;
  logic              RST_Sqrt;
  logic              PRE_Acc;
  logic [ADDR_W-1:0] ADDR_Bram;
  logic [3:0]        FLAG_Bram;
  logic [ELEM_W-1:0] ELEM_IDX;
  logic              DATA_VALID;
  logic [VEC_W-1:0]  VEC_IDX;
  logic              RESULT_VALID;
  logic              DONE;
  logic              ERR;

  modport master (
    input  STARTCALC, NUM_OF_VECTORS, VECTOR_WIDTH, RDY_Pipe, RDY_Acc, RDY_Sqrt,
    output EN_Pipe, EN_Acc, EN_Sqrt, RST_Acc, RST_Sqrt, PRE_Acc, ADDR_Bram, FLAG_Bram,
           ELEM_IDX, DATA_VALID, VEC_IDX, RESULT_VALID, DONE, ERR
  );

  modport slave (
    output STARTCALC, NUM_OF_VECTORS, VECTOR_WIDTH, RDY_Pipe, RDY_Acc, RDY_Sqrt,
    input  EN_Pipe, EN_Acc, EN_Sqrt, RST_Acc, RST_Sqrt, PRE_Acc, ADDR_Bram, FLAG_Bram,
           ELEM_IDX, DATA_VALID, VEC_IDX, RESULT_VALID, DONE, ERR
  );
endinterface

// File: rtl/dist_calc_control.sv
// Sequencer for the Euclidean distance datapath: BRAM vector loads, then pipe/acc/sqrt stages.
// Optional stage watchdog enabled by defining DIST_CTRL_TIMEOUT_EN.
module dist_calc_control #(
  parameter int ADDR_W         = 8,
  parameter int ELEM_W         = 4,
  parameter int VEC_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 RST,
  dist_calc_control_if.master bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  localparam int PW = VEC_W + ELEM_W + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD0, S_LOAD1, S_DRAIN, S_CLEAR,
    S_PIPE, S_ACC, S_SQRT, S_NEXT, S_DONE
`ifdef DIST_CTRL_TIMEOUT_EN
    , S_ERROR
`endif
  } state_t;

  state_t            state, state_next;
  logic [VEC_W-1:0]  num_vec;
  logic [ELEM_W-1:0] vec_w;
  logic [VEC_W-1:0]  vec_idx;
  logic [ELEM_W-1:0] elem;
  logic              acc_first;
  logic              data_valid_q;
  logic [ELEM_W-1:0] elem_idx_q;

  logic              start_ok;
  logic              elem_last;
  logic              reading;
  logic [PW-1:0]     lin_addr;
  logic              en_pipe, en_acc, en_sqrt, rst_acc, rst_sqrt, pre_acc;
  logic              result_valid, done, err;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        flag;

  assign start_ok  = bus.STARTCALC && (bus.NUM_OF_VECTORS != '0) && (bus.VECTOR_WIDTH != '0);
  assign elem_last = (elem == vec_w - ELEM_W'(1));
  assign reading   = (state == S_LOAD0) || (state == S_LOAD1);
  assign lin_addr  = PW'(vec_idx) * PW'(vec_w) + PW'(elem);

`ifdef DIST_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          wait_expired;

  assign wait_expired = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Restarts on every state change, so each wait stage gets a fresh budget.
  always_ff @(posedge clk) begin
    if (RST || state_next != state) wait_cnt <= '0;
    else                            wait_cnt <= wait_cnt + TW'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      state        <= S_IDLE;
      num_vec      <= '0;
      vec_w        <= '0;
      vec_idx      <= '0;
      elem         <= '0;
      acc_first    <= 1'b0;
      data_valid_q <= 1'b0;
      elem_idx_q   <= '0;
    end else begin
      state        <= state_next;
      acc_first    <= (state_next == S_ACC) && (state != S_ACC);
      data_valid_q <= reading;
      elem_idx_q   <= reading ? elem : '0;
      case (state)
        S_IDLE: if (start_ok) begin
          num_vec <= bus.NUM_OF_VECTORS;
          vec_w   <= bus.VECTOR_WIDTH;
          vec_idx <= VEC_W'(1);
          elem    <= '0;
        end
        S_LOAD0, S_LOAD1: elem <= elem_last ? '0 : elem + ELEM_W'(1);
        S_NEXT: if (vec_idx != num_vec) vec_idx <= vec_idx + VEC_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    en_pipe      = 1'b0;
    en_acc       = 1'b0;
    en_sqrt      = 1'b0;
    rst_acc      = 1'b0;
    rst_sqrt     = 1'b0;
    pre_acc      = 1'b0;
    result_valid = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    addr         = '0;
    flag         = 4'b0000;
    case (state)
      S_IDLE:  if (start_ok) state_next = S_LOAD0;
      S_LOAD0: begin
        addr = ADDR_W'(elem);
        flag = 4'b1011;
        if (elem_last) state_next = S_LOAD1;
      end
      S_LOAD1: begin
        addr = ADDR_W'(lin_addr);
        flag = 4'b1010;
        if (elem_last) state_next = S_DRAIN;
      end
      S_DRAIN: state_next = S_CLEAR;
      S_CLEAR: begin
        rst_acc    = 1'b1;
        rst_sqrt   = 1'b1;
        state_next = S_PIPE;
      end
      S_PIPE: begin
        en_pipe = 1'b1;
        if (bus.RDY_Pipe) state_next = S_ACC;
      end
      S_ACC: begin
        en_acc  = 1'b1;
        pre_acc = acc_first;
        if (bus.RDY_Acc) state_next = S_SQRT;
      end
      S_SQRT: begin
        en_sqrt = 1'b1;
        if (bus.RDY_Sqrt) state_next = S_NEXT;
      end
      S_NEXT: begin
        result_valid = 1'b1;
        state_next   = (vec_idx == num_vec) ? S_DONE : S_LOAD1;
      end
      S_DONE: begin
        done = 1'b1;
        if (!bus.STARTCALC) state_next = S_IDLE;
      end
`ifdef DIST_CTRL_TIMEOUT_EN
      S_ERROR: err = 1'b1;
`endif
      default: state_next = S_IDLE;
    endcase
`ifdef DIST_CTRL_TIMEOUT_EN
    // Overrides the stay-in-stage decision only once the budget is exhausted.
    if ((state == S_PIPE || state == S_ACC || state == S_SQRT) &&
        state_next == state && wait_expired)
      state_next = S_ERROR;
`endif
  end

  assign bus.EN_Pipe      = en_pipe;
  assign bus.EN_Acc       = en_acc;
  assign bus.EN_Sqrt      = en_sqrt;
  assign bus.RST_Acc      = rst_acc;
  assign bus.RST_Sqrt     = rst_sqrt;
  assign bus.PRE_Acc      = pre_acc;
  assign bus.ADDR_Bram    = addr;
  assign bus.FLAG_Bram    = flag;
  assign bus.ELEM_IDX     = elem_idx_q;
  assign bus.DATA_VALID   = data_valid_q;
  assign bus.VEC_IDX      = vec_idx;
  assign bus.RESULT_VALID = result_valid;
  assign bus.DONE         = done;
  assign bus.ERR          = err;

endmodule

// File: tb/tb_dist_calc_control.sv
// Bench for dist_calc_control: phase-level trace model with randomized sizes and stage latencies.
module tb_dist_calc_control;

  typedef struct packed {
    logic       en_pipe, en_acc, en_sqrt, rst_acc, rst_sqrt, pre_acc;
    logic [7:0] addr;
    logic [3:0] flag;
    logic       dv;
    logic [3:0] eidx;
    logic [3:0] vidx;
    logic       rv, done, err;
  } rec_t;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  dist_calc_control_if #(.ADDR_W(8), .ELEM_W(4), .VEC_W(4)) bus ();

  dist_calc_control #(.ADDR_W(8), .ELEM_W(4), .VEC_W(4), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk),
    .RST(RST),
    .bus(bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  rec_t        exp_q[$];
  int unsigned d_p, d_a, d_s;
  bit          m_rd;
  int unsigned m_e;
  int unsigned cnt_en_acc, cnt_pre, cnt_overlap;

  function automatic rec_t sample();
    rec_t r;
    r.en_pipe  = bus.EN_Pipe;
    r.en_acc   = bus.EN_Acc;
    r.en_sqrt  = bus.EN_Sqrt;
    r.rst_acc  = bus.RST_Acc;
    r.rst_sqrt = bus.RST_Sqrt;
    r.pre_acc  = bus.PRE_Acc;
    r.addr     = bus.ADDR_Bram;
    r.flag     = bus.FLAG_Bram;
    r.dv       = bus.DATA_VALID;
    r.eidx     = bus.ELEM_IDX;
    r.vidx     = bus.VEC_IDX;
    r.rv       = bus.RESULT_VALID;
    r.done     = bus.DONE;
    r.err      = bus.ERR;
    return r;
  endfunction

  // Each cycle's BRAM data-valid/element reflects the read issued the cycle before.
  function automatic void push(input rec_t r, input bit rd, input int unsigned e);
    r.dv   = m_rd;
    r.eidx = m_rd ? 4'(m_e) : 4'd0;
    m_rd   = rd;
    m_e    = e;
    exp_q.push_back(r);
  endfunction

  function automatic void build_trace(input int unsigned n, input int unsigned w);
    rec_t r;
    exp_q.delete();
    m_rd = 1'b0;
    m_e  = 0;
    for (int unsigned e = 0; e < w; e++) begin
      r = '0; r.addr = 8'(e); r.flag = 4'b1011; r.vidx = 4'd1; push(r, 1'b1, e);
    end
    for (int unsigned v = 1; v <= n; v++) begin
      for (int unsigned e = 0; e < w; e++) begin
        r = '0; r.addr = 8'((v * w + e) % 256); r.flag = 4'b1010; r.vidx = 4'(v); push(r, 1'b1, e);
      end
      r = '0; r.vidx = 4'(v); push(r, 1'b0, 0);
      r = '0; r.vidx = 4'(v); r.rst_acc = 1'b1; r.rst_sqrt = 1'b1; push(r, 1'b0, 0);
      for (int unsigned i = 0; i <= d_p; i++) begin
        r = '0; r.vidx = 4'(v); r.en_pipe = 1'b1; push(r, 1'b0, 0);
      end
      for (int unsigned i = 0; i <= d_a; i++) begin
        r = '0; r.vidx = 4'(v); r.en_acc = 1'b1; r.pre_acc = (i == 0); push(r, 1'b0, 0);
      end
      for (int unsigned i = 0; i <= d_s; i++) begin
        r = '0; r.vidx = 4'(v); r.en_sqrt = 1'b1; push(r, 1'b0, 0);
      end
      r = '0; r.vidx = 4'(v); r.rv = 1'b1; push(r, 1'b0, 0);
    end
    r = '0; r.vidx = 4'(n); r.done = 1'b1; push(r, 1'b0, 0);
  endfunction

  // Start a calculation and check every cycle against the model; stage stubs raise RDY after d_* enabled cycles.
  task automatic run(input int unsigned n, input int unsigned w, input bit hold, output int unsigned rv_cycle);
    rec_t act, ex;
    int unsigned cp = 0, ca = 0, cs = 0;
    build_trace(n, w);
    rv_cycle    = 0;
    cnt_en_acc  = 0;
    cnt_pre     = 0;
    cnt_overlap = 0;
    @(negedge clk);
    bus.NUM_OF_VECTORS = 4'(n);
    bus.VECTOR_WIDTH   = 4'(w);
    bus.STARTCALC      = 1'b1;
    bus.RDY_Pipe = 1'b0; bus.RDY_Acc = 1'b0; bus.RDY_Sqrt = 1'b0;
    for (int unsigned k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      act = sample();
      ex  = exp_q[k];
      if (!ex.dv) act.eidx = 4'd0;
      n_cmp++;
      if (act !== ex) begin
        n_bad++;
        $display("FAIL trace[%0d] N=%0d W=%0d: got %h expected %h", k, n, w, act, ex);
      end
      if (act.rv && rv_cycle == 0) rv_cycle = k + 1;
      if (act.en_acc) cnt_en_acc++;
      if (act.pre_acc) cnt_pre++;
      if (int'(act.en_pipe) + int'(act.en_acc) + int'(act.en_sqrt) > 1) cnt_overlap++;
      bus.RDY_Pipe = act.en_pipe && (cp >= d_p);
      bus.RDY_Acc  = act.en_acc && (ca >= d_a);
      bus.RDY_Sqrt = act.en_sqrt && (cs >= d_s);
      cp = act.en_pipe ? cp + 1 : 0;
      ca = act.en_acc ? ca + 1 : 0;
      cs = act.en_sqrt ? cs + 1 : 0;
      bus.STARTCALC = hold ? 1'b1 : ((k == exp_q.size() - 1) ? 1'b0 : 1'($urandom_range(0, 1)));
    end
    bus.RDY_Pipe = 1'b0; bus.RDY_Acc = 1'b0; bus.RDY_Sqrt = 1'b0;
  endtask

  task automatic test_reset();
    rec_t act;
    RST = 1'b1;
    repeat (2) @(negedge clk);
    act = sample();
    n_cmp++;
    if (act !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0", act);
    end
    RST = 1'b0;
  endtask

  task automatic test_single_vector();
    int unsigned rvc;
    d_p = 0; d_a = 0; d_s = 0;
    run(1, 3, 1'b0, rvc);
    n_cmp++;
    if (rvc !== 12) begin
      n_bad++;
      $display("FAIL result_valid_cycle: got %0d expected 12", rvc);
    end
  endtask

  task automatic test_two_vectors();
    int unsigned rvc;
    d_p = 0; d_a = 0; d_s = 0;
    run(2, 2, 1'b0, rvc);
  endtask

  task automatic test_acc_delay();
    int unsigned rvc;
    d_p = 0; d_a = 5; d_s = 0;
    run(1, 2, 1'b0, rvc);
    n_cmp++;
    if (cnt_en_acc !== 6 || cnt_pre !== 1 || cnt_overlap !== 0) begin
      n_bad++;
      $display("FAIL acc_delay: got en_acc=%0d pre=%0d overlap=%0d expected 6 1 0", cnt_en_acc, cnt_pre, cnt_overlap);
    end
  endtask

  task automatic test_random();
    int unsigned rvc;
    for (int i = 0; i < 8; i++) begin
      d_p = $urandom_range(0, 4); d_a = $urandom_range(0, 4); d_s = $urandom_range(0, 4);
      run($urandom_range(1, 15), $urandom_range(1, 15), 1'b0, rvc);
    end
  endtask

  task automatic test_hold_start();
    int unsigned rvc;
    rec_t act;
    d_p = 0; d_a = 0; d_s = 0;
    run(1, 1, 1'b1, rvc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      act = sample();
      n_cmp++;
      if (!act.done || act.en_pipe || act.en_acc || act.en_sqrt || act.flag !== 4'b0000) begin
        n_bad++;
        $display("FAIL hold_done[%0d]: got %h expected DONE only", i, act);
      end
    end
    bus.STARTCALC = 1'b0;
    @(negedge clk);
    act = sample();
    n_cmp++;
    if (act.done || act.flag !== 4'b0000 || act.en_pipe) begin
      n_bad++;
      $display("FAIL release_to_idle: got %h expected idle", act);
    end
  endtask

  task automatic test_zero_counts();
    rec_t act;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.NUM_OF_VECTORS = (c == 0) ? 4'd0 : 4'd2;
      bus.VECTOR_WIDTH   = (c == 0) ? 4'd3 : 4'd0;
      bus.STARTCALC      = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        act = sample();
        n_cmp++;
        if (act.flag !== 4'b0000 || act.done || act.en_pipe || act.rst_acc || act.dv) begin
          n_bad++;
          $display("FAIL zero_count_start[%0d,%0d]: got %h expected idle", c, i, act);
        end
      end
      bus.STARTCALC = 1'b0;
    end
  endtask

  task automatic test_reset_mid_sqrt();
    rec_t act;
    bit   seen = 1'b0;
    @(negedge clk);
    bus.NUM_OF_VECTORS = 4'd2; bus.VECTOR_WIDTH = 4'd2; bus.STARTCALC = 1'b1;
    bus.RDY_Pipe = 1'b1; bus.RDY_Acc = 1'b1; bus.RDY_Sqrt = 1'b0;
    @(negedge clk);
    bus.STARTCALC = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.EN_Sqrt) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL reach_sqrt: got no EN_Sqrt expected within 60 cycles");
    end
    RST = 1'b1;
    @(negedge clk);
    act = sample();
    n_cmp++;
    if (act !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_sqrt: got %h expected 0", act);
    end
    RST = 1'b0;
    bus.RDY_Pipe = 1'b0; bus.RDY_Acc = 1'b0;
  endtask

`ifdef DIST_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    rec_t act;
    int unsigned pipe_cycles = 0;
    bit erred = 1'b0;
    @(negedge clk);
    bus.NUM_OF_VECTORS = 4'd1; bus.VECTOR_WIDTH = 4'd1; bus.STARTCALC = 1'b1;
    bus.RDY_Pipe = 1'b0; bus.RDY_Acc = 1'b0; bus.RDY_Sqrt = 1'b0;
    @(negedge clk);
    bus.STARTCALC = 1'b0;
    for (int i = 0; i < 40 && !erred; i++) begin
      act = sample();
      if (act.err) erred = 1'b1;
      else begin
        if (act.en_pipe) pipe_cycles++;
        @(negedge clk);
      end
    end
    n_cmp++;
    if (!erred || pipe_cycles !== 10 || act.en_pipe) begin
      n_bad++;
      $display("FAIL timeout: got err=%0d pipe_cycles=%0d en_pipe=%0d expected 1 10 0", erred, pipe_cycles, act.en_pipe);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.ERR !== 1'b1) begin
      n_bad++;
      $display("FAIL err_held: got %0d expected 1", bus.ERR);
    end
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    n_cmp++;
    if (bus.ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL err_cleared: got %0d expected 0", bus.ERR);
    end
  endtask
`endif

  initial begin
    RST = 1'b1;
    bus.STARTCALC = 1'b0;
    bus.NUM_OF_VECTORS = '0;
    bus.VECTOR_WIDTH = '0;
    bus.RDY_Pipe = 1'b0; bus.RDY_Acc = 1'b0; bus.RDY_Sqrt = 1'b0;
    test_reset();
    test_single_vector();
    test_two_vectors();
    test_acc_delay();
    test_random();
    test_hold_start();
    test_zero_counts();
    test_reset_mid_sqrt();
`ifdef DIST_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
